// File: rtl/store_buffer_pkg.sv
// Shared types and constants for the MEM-stage posted-write store buffer.
package store_buffer_pkg;
  localparam int SB_AW      = 30;
  localparam int SB_DEPTH   = 4;
  localparam int SB_ENTRY_W = SB_AW + 32 + 4;

  typedef enum logic [1:0] {
    BE_SW = 2'd0,
    BE_SH = 2'd1,
    BE_SB = 2'd2
  } st_op_e;

  typedef struct packed {
    logic [SB_AW-1:0] addr;
    logic [31:0]      data;
    logic [3:0]       be;
  } sb_entry_t;

  // Replicate the low half/byte across all lanes so the byte enables pick the right one.
  function automatic logic [31:0] lane_data(input logic [1:0] op, input logic [31:0] d);
    case (op)
      BE_SH:   return {2{d[15:0]}};
      BE_SB:   return {4{d[7:0]}};
      default: return d;
    endcase
  endfunction
endpackage

// File: rtl/store_buffer_if.sv
// Store, load-probe and data-memory bus signals of the store buffer.
interface store_buffer_if;
  import store_buffer_pkg::*;
  logic             st_valid;
  logic [31:0]      st_addr;
  logic [31:0]      st_data;
  logic [1:0]       st_op;
  logic [3:0]       st_be;
  logic             st_full;
  logic             ld_valid;
  logic [31:0]      ld_addr;
  logic             ld_hazard;
  logic             mem_req;
  logic [SB_AW-1:0] mem_addr;
  logic [31:0]      mem_wdata;
  logic [3:0]       mem_be;
  logic             mem_ack;
  logic             sb_empty;

  modport slave (
    input  st_valid, st_addr, st_data, st_op, st_be, ld_valid, ld_addr, mem_ack,
    output st_full, ld_hazard, mem_req, mem_addr, mem_wdata, mem_be, sb_empty
  );
  modport master (
    output st_valid, st_addr, st_data, st_op, st_be, ld_valid, ld_addr, mem_ack,
    input  st_full, ld_hazard, mem_req, mem_addr, mem_wdata, mem_be, sb_empty
  );
endinterface

// File: rtl/sbuf_fifo.sv
// Circular FIFO with occupancy count; exports all slots plus a per-slot valid vector.
module sbuf_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 66
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push_i,
  input  logic [W-1:0]                din_i,
  input  logic                        pop_i,
  output logic [W-1:0]                head_o,
  output logic [$clog2(DEPTH):0]      count_o,
  output logic [DEPTH-1:0]            vld_o,
  output logic [DEPTH-1:0][W-1:0]     ent_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [PW-1:0]           wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    do_push, do_pop;

  // A full buffer refuses the push even when the head pops in the same cycle.
  assign do_push = push_i && (cnt_q != CW'(DEPTH));
  assign do_pop  = pop_i && (cnt_q != '0);

  always_comb begin
    wr_d  = wr_q + PW'(do_push);
    rd_d  = rd_q + PW'(do_pop);
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      mem_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      if (do_push) mem_q[wr_q] <= din_i;
    end
  end

  // Slot g is live when its distance from the read pointer is below the count.
  for (genvar g = 0; g < DEPTH; g++) begin : g_vld
    wire [PW-1:0] off = PW'(g) - rd_q;
    assign vld_o[g] = {1'b0, off} < cnt_q;
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  assign ent_o   = mem_q;
endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer: lane replication, FIFO queueing, memory drain, load hazard detect.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  store_buffer_if.slave sb
);
  localparam int CW = $clog2(DEPTH) + 1;

  sb_entry_t                        st_ent, head;
  logic [SB_ENTRY_W-1:0]            head_vec;
  logic [DEPTH-1:0][SB_ENTRY_W-1:0] ent;
  logic [DEPTH-1:0]                 vld, hit;
  logic [CW-1:0]                    cnt;
  logic                             push, pop;
  logic                             unused_lo;

  assign push   = sb.st_valid && (sb.st_be != 4'b0);
  assign pop    = sb.mem_ack && sb.mem_req;
  assign st_ent = '{addr: sb.st_addr[31:2], data: lane_data(sb.st_op, sb.st_data), be: sb.st_be};

  sbuf_fifo #(.DEPTH(DEPTH), .W(SB_ENTRY_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (st_ent),
    .pop_i   (pop),
    .head_o  (head_vec),
    .count_o (cnt),
    .vld_o   (vld),
    .ent_o   (ent)
  );

  assign head         = sb_entry_t'(head_vec);
  assign sb.mem_req   = (cnt != '0);
  assign sb.sb_empty  = (cnt == '0);
  assign sb.st_full   = (cnt == CW'(DEPTH));
  assign sb.mem_addr  = head.addr;
  assign sb.mem_wdata = head.data;
  assign sb.mem_be    = head.be;

  // Word-granular match only; byte-lane overlap is deliberately not examined.
  for (genvar g = 0; g < DEPTH; g++) begin : g_hit
    sb_entry_t e;
    assign e      = sb_entry_t'(ent[g]);
    assign hit[g] = vld[g] && (e.addr == sb.ld_addr[31:2]);
  end

  assign sb.ld_hazard = sb.ld_valid && (|hit);
  assign unused_lo    = ^{sb.st_addr[1:0], sb.ld_addr[1:0]};
endmodule
